// File: rtl/gpca_seq.sv
// gpca_seq: request sequencer and operand formatter for the combinational gpca array.
// Loads and left-normalizes operands, holds them for SETTLE cycles, then captures F/S.
module gpca_seq #(
  parameter int unsigned SETTLE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_a,
  input  logic [4:0]  req_b,
  output logic        X,
  output logic [1:5]  P,
  output logic [1:10] A,
  output logic [1:7]  B,
  output logic [1:7]  C,
  input  logic [1:5]  F,
  input  logic [1:11] S,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:5]  res_f,
  output logic [1:11] res_s,
  output logic [3:0]  res_sha,
  output logic [2:0]  res_shb,
  output logic        res_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NORM   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_SQUARE = 2'b01,
    OP_SQRT   = 2'b10,
    OP_DIV    = 2'b11
  } op_t;

  state_t       state_q, state_d;
  logic         x_q, x_d;
  logic [1:5]   p_q, p_d;
  logic [1:10]  a_q, a_d;
  logic [1:7]   b_q, b_d;
  logic [1:7]   c_q, c_d;
  logic [1:5]   f_q, f_d;
  logic [1:11]  s_q, s_d;
  logic [3:0]   sha_q, sha_d;
  logic [2:0]   shb_q, shb_d;
  logic         err_q, err_d;
  logic         bad_q, bad_d;       // request fails validation, flagged at accept
  logic         norm_a_q, norm_a_d; // A takes part in normalization
  logic         norm_b_q, norm_b_d; // B/C take part in normalization
  logic [7:0]   cnt_q, cnt_d;
  logic         busy_a, busy_b;
  op_t          op;

  assign op     = op_t'(req_op);
  assign busy_a = norm_a_q & ~a_q[1];
  assign busy_b = norm_b_q & ~b_q[1];

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign X       = x_q;
  assign P       = p_q;
  assign A       = a_q;
  assign B       = b_q;
  assign C       = c_q;
  assign res_f   = f_q;
  assign res_s   = s_q;
  assign res_sha = sha_q;
  assign res_shb = shb_q;
  assign res_err = err_q;

  // Next-state and datapath update for accept, normalize, settle and hand-off.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    p_d      = p_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    f_d      = f_q;
    s_d      = s_q;
    sha_d    = sha_q;
    shb_d    = shb_q;
    err_d    = err_q;
    bad_d    = bad_q;
    norm_a_d = norm_a_q;
    norm_b_d = norm_b_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_NORM;
          sha_d    = '0;
          shb_d    = '0;
          bad_d    = (((op == OP_MUL) || (op == OP_SQUARE)) && (req_a[9:5] != '0)) ||
                     ((op == OP_DIV) && ((req_b == '0) || (req_a == '0)));
          norm_a_d = (op == OP_DIV);
          // A zero multiplier can never reach MSB=1, so it is left un-normalized.
          norm_b_d = (op == OP_DIV) || ((op == OP_MUL) && (req_b != '0));
          unique case (op)
            OP_MUL: begin
              x_d = 1'b0; p_d = req_a[4:0]; a_d = '0;
              b_d = {req_b, 2'b00}; c_d = {req_b, 2'b00};
            end
            OP_SQUARE: begin
              x_d = 1'b0; p_d = req_a[4:0]; a_d = '0;
              b_d = 7'b0011111; c_d = 7'b0100000;
            end
            OP_SQRT: begin
              x_d = 1'b1; p_d = '0; a_d = req_a;
              b_d = 7'b0011111; c_d = 7'b0100000;
            end
            default: begin
              x_d = 1'b1; p_d = '0; a_d = req_a;
              b_d = {req_b, 2'b00}; c_d = {req_b, 2'b00};
            end
          endcase
        end
      end
      S_NORM: begin
        if (bad_q) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          f_d     = '0;
          s_d     = '0;
        end else begin
          if (busy_a) begin
            a_d   = {a_q[2:10], 1'b0};
            sha_d = sha_q + 4'd1;
          end
          if (busy_b) begin
            b_d   = {b_q[2:7], 1'b0};
            c_d   = {c_q[2:7], 1'b0};
            shb_d = shb_q + 3'd1;
          end
          if (!busy_a && !busy_b) begin
            state_d = S_SETTLE;
            cnt_d   = 8'(SETTLE - 1);
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          f_d     = F;
          s_d     = S;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset clears everything back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= 1'b0;
      p_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      f_q      <= '0;
      s_q      <= '0;
      sha_q    <= '0;
      shb_q    <= '0;
      err_q    <= 1'b0;
      bad_q    <= 1'b0;
      norm_a_q <= 1'b0;
      norm_b_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      p_q      <= p_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      f_q      <= f_d;
      s_q      <= s_d;
      sha_q    <= sha_d;
      shb_q    <= shb_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
      norm_a_q <= norm_a_d;
      norm_b_q <= norm_b_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gpca_seq.sv
// Self-checking bench for gpca_seq: directed table, handshake/reset sequences, random ops.
module tb_gpca_seq;
  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_a;
  logic [4:0]  req_b;
  logic        X;
  logic [1:5]  P;
  logic [1:10] A;
  logic [1:7]  B;
  logic [1:7]  C;
  logic [1:5]  F;
  logic [1:11] S;
  logic        res_valid;
  logic        res_ready;
  logic [1:5]  res_f;
  logic [1:11] res_s;
  logic [3:0]  res_sha;
  logic [2:0]  res_shb;
  logic        res_err;

  int n_tests = 0;
  int n_fail  = 0;
  int tick    = 0;

  gpca_seq #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .X(X), .P(P), .A(A), .B(B), .C(C), .F(F), .S(S),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_s(res_s), .res_sha(res_sha), .res_shb(res_shb),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number N, tick == N.
  always @(posedge clk) tick <= tick + 1;

  function automatic logic [4:0] fv(input int t);
    return 5'(t * 13 + 7);
  endfunction
  function automatic logic [10:0] sv(input int t);
    return 11'(t * 97 + 3);
  endfunction

  // Fake array outputs change every cycle; the value seen at edge N+1 is fv(N)/sv(N).
  always @(negedge clk) begin
    F = fv(tick);
    S = sv(tick);
  end

  typedef struct {
    logic [1:0] op;
    logic [9:0] a;
    logic [4:0] b;
    logic       x;
    logic [4:0] p;
    logic [9:0] av;
    logic [6:0] bv;
    logic [6:0] cv;
    int         sha;
    int         shb;
    logic       err;
    int         lat;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [9:0] a, input logic [4:0] b,
                              input logic x, input logic [4:0] p, input logic [9:0] av,
                              input logic [6:0] bv, input logic [6:0] cv, input int sha,
                              input int shb, input logic err, input int lat);
    vec_t e;
    e.op = op; e.a = a; e.b = b; e.x = x; e.p = p; e.av = av; e.bv = bv; e.cv = cv;
    e.sha = sha; e.shb = shb; e.err = err; e.lat = lat;
    return e;
  endfunction

  // Reference: operand formatting and normalization as arithmetic (double until >= half-range).
  function automatic vec_t model(input logic [1:0] op, input logic [9:0] a, input logic [4:0] b);
    vec_t e;
    int av, bv, cv, k;
    logic uses_b;
    uses_b = (op == 2'd0) || (op == 2'd3);
    e.op = op; e.a = a; e.b = b;
    e.x  = (op >= 2'd2);
    e.p  = (op <= 2'd1) ? a[4:0] : 5'd0;
    av   = (op >= 2'd2) ? int'(a) : 0;
    bv   = uses_b ? int'(b) * 4 : 31;
    cv   = uses_b ? int'(b) * 4 : 32;
    e.err = ((op <= 2'd1) && (a > 10'd31)) || ((op == 2'd3) && ((a == 10'd0) || (b == 5'd0)));
    e.sha = 0;
    e.shb = 0;
    if (!e.err) begin
      if (op == 2'd3) while (av < 512) begin av = av * 2; e.sha++; end
      if (uses_b && bv != 0) while (bv < 64) begin bv = bv * 2; cv = cv * 2; e.shb++; end
    end
    e.av = 10'(av);
    e.bv = 7'(bv);
    e.cv = 7'(cv);
    k = (e.sha > e.shb) ? e.sha : e.shb;
    e.lat = e.err ? 1 : k + 1 + SETTLE;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [4:0] b,
                       output int t0);
    @(negedge clk);
    chk("req_ready_idle", int'(req_ready), 1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    t0 = tick;
    chk("req_ready_busy", int'(req_ready), 0);
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_a  = 10'($urandom);
    req_b  = 5'($urandom);
  endtask

  task automatic wait_valid(output int tv);
    tv = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_valid) begin
        tv = tick;
        break;
      end
    end
    if (tv < 0) chk("timeout_res_valid", 0, 1);
  endtask

  task automatic cmp_res(input vec_t e, input int tv);
    chk("X", int'(X), int'(e.x));
    chk("P", int'(P), int'(e.p));
    chk("A", int'(A), int'(e.av));
    chk("B", int'(B), int'(e.bv));
    chk("C", int'(C), int'(e.cv));
    chk("res_sha", int'(res_sha), e.sha);
    chk("res_shb", int'(res_shb), e.shb);
    chk("res_err", int'(res_err), int'(e.err));
    chk("res_f", int'(res_f), e.err ? 0 : int'(fv(tv - 1)));
    chk("res_s", int'(res_s), e.err ? 0 : int'(sv(tv - 1)));
  endtask

  task automatic collect(input vec_t e, input int t0);
    int tv;
    wait_valid(tv);
    if (tv < 0) return;
    chk("latency", tv - t0, e.lat);
    cmp_res(e, tv);
    @(negedge clk);
    chk("valid_drop", int'(res_valid), 0);
    chk("ready_back", int'(req_ready), 1);
  endtask

  vec_t tbl[8];

  initial begin
    int t0, tv;
    vec_t e;
    tbl[0] = mk(2'd0, 10'd5,    5'd7, 1'b0, 5'd5, 10'd0,           7'b1110000, 7'b1110000, 0, 2, 1'b0, 11);
    tbl[1] = mk(2'd1, 10'd5,    5'd9, 1'b0, 5'd5, 10'd0,           7'b0011111, 7'b0100000, 0, 0, 1'b0, 9);
    tbl[2] = mk(2'd1, 10'h020,  5'd0, 1'b0, 5'd0, 10'd0,           7'b0011111, 7'b0100000, 0, 0, 1'b1, 1);
    tbl[3] = mk(2'd2, 10'd25,   5'd3, 1'b1, 5'd0, 10'b0000011001,  7'b0011111, 7'b0100000, 0, 0, 1'b0, 9);
    tbl[4] = mk(2'd3, 10'd35,   5'd5, 1'b1, 5'd0, 10'b1000110000,  7'b1010000, 7'b1010000, 4, 2, 1'b0, 13);
    tbl[5] = mk(2'd3, 10'd35,   5'd0, 1'b1, 5'd0, 10'd35,          7'd0,       7'd0,       0, 0, 1'b1, 1);
    tbl[6] = mk(2'd0, 10'd5,    5'd0, 1'b0, 5'd5, 10'd0,           7'd0,       7'd0,       0, 0, 1'b0, 9);
    tbl[7] = mk(2'd3, 10'd1,    5'd1, 1'b1, 5'd0, 10'b1000000000,  7'b1000000, 7'b1000000, 9, 4, 1'b0, 18);

    rst_n = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_array", int'({X, P, A, B, C}), 0);
    chk("rst_res", int'({res_f, res_s, res_sha, res_shb, res_err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, t0);
      collect(tbl[i], t0);
    end

    // Consumer back-pressure in DONE with a pending request
    res_ready = 1'b0;
    e = model(2'd0, 10'd5, 5'd7);
    issue(2'd0, 10'd5, 5'd7, t0);
    wait_valid(tv);
    if (tv >= 0) begin
      chk("hold_latency", tv - t0, 11);
      req_op = 2'd2; req_a = 10'd25; req_b = 5'd0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        cmp_res(e, tv);
        chk("hold_valid", int'(res_valid), 1);
        chk("hold_req_ready", int'(req_ready), 0);
        @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_ready", int'(req_ready), 1);
      chk("hold_release_valid", int'(res_valid), 0);
      @(negedge clk);
      t0 = tick;
      chk("pending_accepted", int'(req_ready), 0);
      req_valid = 1'b0;
      collect(model(2'd2, 10'd25, 5'd0), t0);
    end

    // Async reset mid-SETTLE of a DIV, then a normal MUL
    issue(2'd3, 10'd35, 5'd5, t0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", int'(req_ready), 1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_array", int'({X, P, A, B, C}), 0);
    chk("mid_rst_res", int'({res_f, res_s, res_sha, res_shb, res_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 10'd7, 5'd5, t0);
    e = model(2'd0, 10'd7, 5'd5);
    chk("post_rst_model_lat", e.lat, 11);
    collect(e, t0);

    // Random requests against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [9:0] a;
      logic [4:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
      if (op >= 2'd2 && $urandom_range(0, 1) == 1) a = 10'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      issue(op, a, b, t0);
      collect(model(op, a, b), t0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpca_seq.md
# gpca_seq

Sequencer and operand formatter that sits directly upstream of the combinational `gpca` array. It accepts one arithmetic request at a time (multiply, square, square root, divide) over a valid/ready handshake. It formats and left-normalizes the operands into the array's `X/P/A/B/C` inputs, then holds them stable for a programmable settle time. It captures `F` and `S` into a registered result with a valid/ready handshake toward the consumer.

## Interface
- `SETTLE`, default 8, number of cycles the array inputs are held stable before `F`/`S` are captured; legal range 1..255.
- `clk` in 1: sole clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: decoded from state; 1 only in IDLE, including while `rst_n` is low.
- `req_op` in 2: 00 MUL, 01 SQUARE, 10 SQRT, 11 DIV.
- `req_a` in 10: MUL/SQUARE multiplicand in `[4:0]`; SQRT radicand; DIV dividend.
- `req_b` in 5: MUL multiplier, DIV divisor; ignored for SQUARE/SQRT.
- `X` out 1, `P` out [1:5], `A` out [1:10], `B` out [1:7], `C` out [1:7]: registered drive to the array; bit 1 is MSB; all 0 on reset.
- `F` in [1:5], `S` in [1:11]: array outputs.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts.
- `res_f` out [1:5], `res_s` out [1:11]: captured `F`, `S`.
- `res_sha` out 4: left-shift count applied to `A`, range 0..9.
- `res_shb` out 3: left-shift count applied to `B`/`C`, range 0..4.
- `res_err` out 1: request rejected; `res_f`/`res_s` are 0 when set.

## Operation
- States: IDLE, NORM, SETTLE, DONE. Reset enters IDLE.
- **IDLE**
  - On `req_valid & req_ready`, load the operand registers per op, clear the shift counters, and go to NORM.
  - MUL: `X=0`, `P=req_a[4:0]`, `A=0`, `B=C={req_b,2'b00}`; normalize B/C.
  - SQUARE: `X=0`, `P=req_a[4:0]`, `A=0`, `B=7'b0011111`, `C=7'b0100000`; no normalization.
  - SQRT: `X=1`, `P=0`, `A=req_a` right-justified, `B=7'b0011111`, `C=7'b0100000`; no normalization.
  - DIV: `X=1`, `P=0`, `A=req_a`, `B=C={req_b,2'b00}`; normalize both A and B/C.
- **NORM**
  - Error check on the first NORM cycle. Go to DONE with `res_err=1` if either condition holds:
    - MUL/SQUARE with `req_a[9:5]!=0`;
    - DIV with `req_b==0` or `req_a==0`.
  - MUL with `req_b==0` is not an error; the B normalizer is treated as done at zero, so `shb=0`.
  - Each cycle, for each operand being normalized whose MSB (`A[1]`, `B[1]`) is 0: shift left by 1, zero-fill, and increment its counter. B and C always shift together.
  - When all normalized operands have MSB=1, go to SETTLE and load the settle counter with `SETTLE-1`.
- **SETTLE**
  - Array inputs are frozen. Decrement the counter each cycle.
  - At counter 0: capture `F`→`res_f` and `S`→`res_s`, set `res_err=0`, and go to DONE.
- **DONE**
  - `res_*` are held stable while `res_valid=1`.
  - On `res_ready`, go to IDLE. There is no same-cycle re-accept, so one bubble occurs between operations.
  - Array inputs keep their last value until the next accept.

## Timing
- Reset values: `req_ready=1`, `res_valid=0`, and all `res_*`, `X`, `P`, `A`, `B`, `C` = 0.
- Accept on edge T0. NORM occupies k+1 cycles, where k = max(`sha`, `shb`).
- `res_valid` rises on edge T0+k+1+SETTLE.
  - Example, default SETTLE: MUL 7×5 (k=2) → 11 cycles after accept; SQUARE/SQRT → 9 cycles.
- Error path: `res_valid` rises on edge T0+1.
- `res_valid` is registered and falls on the edge after `res_valid & res_ready`. `req_ready` rises on that same edge.
- Asynchronous reset at any state discards the in-flight request. Outputs return immediately to their reset values, and no result is produced.
- `req_*` are sampled only at accept; changes at any other time are ignored.

## Test plan
- MUL `req_a=5`, `req_b=7`:
  - array inputs settle to `X=0`, `P=00101`, `A=0`, `B=C=1110000`;
  - `res_shb=2`, `res_sha=0`;
  - `res_valid` 11 cycles after accept, with `res_f`/`res_s` equal to the values applied on `F`/`S` at capture.
- SQUARE `req_a=5`: `P=00101`, `B=0011111`, `C=0100000`, `X=0`; latency 9. Repeat with `req_a=10'h020` → `res_err=1` at T0+1, `res_f=res_s=0`.
- SQRT `req_a=25`: `X=1`, `P=0`, `A=0000011001`, `B=0011111`, `C=0100000`; latency 9; shift counts 0.
- DIV `req_a=35`, `req_b=5`:
  - `A=1000110000`, `B=C=1010000`;
  - `res_sha=4`, `res_shb=2`; latency 13.
  - Repeat with `req_b=0` → `res_err=1` at T0+1.
- Hold `res_ready=0` for 5 cycles in DONE:
  - `res_*` are stable, `req_ready=0`, and a pending `req_valid` is not accepted;
  - after `res_ready`, `req_ready=1` one cycle later and the next request is accepted.
- Assert `rst_n=0` mid-SETTLE of a DIV: outputs are 0 and `req_ready=1` immediately. After release, a MUL 7×5 completes normally in 11 cycles.
